// File: rtl/uart_debug_controller_if.sv
// Word-level UART handshake between the debug controller (master) and the UART
// word buffers (slave): received-word strobe in, transmit start/data out.
interface uart_debug_controller_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  i_rx_valid;
    logic [WORD_WIDTH-1:0] i_rx_data;
    logic                  i_tx_ready;
    logic                  o_tx_start;
    logic [WORD_WIDTH-1:0] o_tx_data;

    modport master (
        input  i_rx_valid,
        input  i_rx_data,
        input  i_tx_ready,
        output o_tx_start,
        output o_tx_data
    );

    modport slave (
        output i_rx_valid,
        output i_rx_data,
        output i_tx_ready,
        input  o_tx_start,
        input  o_tx_data
    );
endinterface

// File: rtl/uart_debug_controller.sv
// Debug / program-load controller: decodes ASCII command words, streams program
// words into instruction memory, runs or single-steps the CPU and dumps its state.
module uart_debug_controller #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_BITS  = 5,
    parameter int DMEM_ADDR_BITS = 8,
    parameter int IMEM_ADDR_BITS = 6,
    parameter int N_LATCHES      = 4,
    parameter int LATCH_WORDS    = 5
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    uart_debug_controller_if.master                    uart,
    output logic                                       o_imem_we,
    output logic [IMEM_ADDR_BITS-1:0]                  o_imem_addr,
    output logic [WORD_WIDTH-1:0]                      o_imem_data,
    output logic                                       o_cpu_reset,
    output logic                                       o_run,
    output logic                                       o_step,
    input  logic                                       i_halted,
    output logic [REG_ADDR_BITS-1:0]                   o_reg_addr,
    input  logic [WORD_WIDTH-1:0]                      i_reg_data,
    output logic [DMEM_ADDR_BITS-1:0]                  o_dmem_addr,
    input  logic [WORD_WIDTH-1:0]                      i_dmem_data,
    input  logic [N_LATCHES*LATCH_WORDS*WORD_WIDTH-1:0] i_latches
);
    localparam int LAT_TOTAL = N_LATCHES * LATCH_WORDS;
    localparam int LAT_BITS  = LAT_TOTAL * WORD_WIDTH;
    localparam int LAT_IDX_W = (LAT_TOTAL > 1) ? $clog2(LAT_TOTAL) : 1;
    localparam logic [LAT_IDX_W-1:0] LAT_LAST = LAT_IDX_W'(LAT_TOTAL - 1);

    localparam logic [31:0] CMD_RINS = "rins";
    localparam logic [31:0] CMD_IEOF = "ieof";
    localparam logic [31:0] CMD_CONT = "cont";
    localparam logic [31:0] CMD_STEP = "step";
    localparam logic [31:0] CMD_DUMP = "dump";
    localparam logic [31:0] CMD_HALT = "halt";

    localparam logic [WORD_WIDTH-1:0] RPL_UNKNOWN = WORD_WIDTH'(32'hEEEE_0000);
    localparam logic [WORD_WIDTH-1:0] RPL_OVF     = WORD_WIDTH'(32'hEEEE_0001);
    localparam logic [WORD_WIDTH-1:0] RPL_HALTED  = WORD_WIDTH'(32'hFFFF_FFFF);
    localparam logic [WORD_WIDTH-1:0] RPL_ABORT   = WORD_WIDTH'(32'hFFFF_FFFE);

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        LOAD,
        RUN,
        STEP,
        DUMP_REG,
        DUMP_MEM,
        DUMP_LAT,
        DUMP_SUM,
        REPLY
    } state_t;

    state_t                  state;
    logic [31:0]             cmd;
    logic [IMEM_ADDR_BITS:0] load_cnt;
    logic                    overflow;
    logic                    run_en;
    logic                    snap_pending;
    logic                    tx_start_q;
    logic [WORD_WIDTH-1:0]   tx_data_q;
    logic [WORD_WIDTH-1:0]   reply_word;
    logic [WORD_WIDTH-1:0]   checksum;
    logic [LAT_IDX_W-1:0]    lat_idx;
    logic [LAT_BITS-1:0]     lat_snap;

    logic                    rx_halt;
    logic                    can_send;
    logic                    sending;
    logic                    dump_data;
    logic                    enter_dump;
    logic [WORD_WIDTH-1:0]   send_word;

    // A host abort or a retired HALT must gate the CPU in the very cycle it is seen,
    // so the run enable is qualified combinationally rather than waiting for the FSM.
    assign rx_halt    = uart.i_rx_valid && (uart.i_rx_data[31:0] == CMD_HALT);
    assign o_run      = run_en && !i_halted && !rx_halt;
    assign o_step     = (state == STEP) && !i_halted;

    assign can_send   = uart.i_tx_ready && !tx_start_q;
    assign dump_data  = (state == DUMP_REG) || (state == DUMP_MEM) || (state == DUMP_LAT);
    assign sending    = can_send && (dump_data || (state == DUMP_SUM) || (state == REPLY));
    assign enter_dump = ((state == DECODE) && (cmd == CMD_DUMP)) ||
                        ((state == STEP) && !i_halted);

    assign uart.o_tx_start = tx_start_q;
    assign uart.o_tx_data  = tx_data_q;

    always_comb begin
        send_word = reply_word;
        case (state)
            DUMP_REG: send_word = i_reg_data;
            DUMP_MEM: send_word = i_dmem_data;
            DUMP_LAT: send_word = lat_snap[int'(lat_idx) * WORD_WIDTH +: WORD_WIDTH];
            DUMP_SUM: send_word = checksum;
            default:  send_word = reply_word;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            cmd          <= '0;
            load_cnt     <= '0;
            overflow     <= 1'b0;
            run_en       <= 1'b0;
            snap_pending <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            reply_word   <= '0;
            checksum     <= '0;
            lat_idx      <= '0;
            lat_snap     <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_data  <= '0;
            o_cpu_reset  <= 1'b0;
            o_reg_addr   <= '0;
            o_dmem_addr  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            o_imem_we  <= 1'b0;

            case (state)
                IDLE: begin
                    if (uart.i_rx_valid) begin
                        cmd   <= uart.i_rx_data[31:0];
                        state <= DECODE;
                    end
                end

                DECODE: begin
                    case (cmd)
                        CMD_RINS: begin
                            state       <= LOAD;
                            load_cnt    <= '0;
                            overflow    <= 1'b0;
                            o_cpu_reset <= 1'b1;
                        end
                        CMD_CONT: begin
                            state  <= RUN;
                            run_en <= 1'b1;
                        end
                        CMD_STEP: state <= STEP;
                        CMD_DUMP: state <= DUMP_REG;
                        default: begin
                            reply_word <= RPL_UNKNOWN;
                            state      <= REPLY;
                        end
                    endcase
                end

                // The counter carries one extra bit so a full memory is told apart
                // from an empty one; once that bit is set every further word is dropped.
                LOAD: begin
                    if (uart.i_rx_valid) begin
                        if (uart.i_rx_data[31:0] == CMD_IEOF) begin
                            o_cpu_reset <= 1'b0;
                            reply_word  <= overflow ? RPL_OVF : WORD_WIDTH'(load_cnt);
                            state       <= REPLY;
                        end else if (load_cnt[IMEM_ADDR_BITS]) begin
                            overflow <= 1'b1;
                        end else begin
                            o_imem_we   <= 1'b1;
                            o_imem_addr <= load_cnt[IMEM_ADDR_BITS-1:0];
                            o_imem_data <= uart.i_rx_data;
                            load_cnt    <= load_cnt + 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (i_halted) begin
                        run_en     <= 1'b0;
                        reply_word <= RPL_HALTED;
                        state      <= REPLY;
                    end else if (rx_halt) begin
                        run_en     <= 1'b0;
                        reply_word <= RPL_ABORT;
                        state      <= REPLY;
                    end
                end

                STEP: begin
                    if (i_halted) begin
                        reply_word <= RPL_HALTED;
                        state      <= REPLY;
                    end else begin
                        state <= DUMP_REG;
                    end
                end

                // Latches are captured in the first dump cycle, after any step has landed.
                DUMP_REG: begin
                    if (snap_pending) begin
                        lat_snap     <= i_latches;
                        snap_pending <= 1'b0;
                    end
                    if (sending) begin
                        o_reg_addr <= o_reg_addr + 1'b1;
                        if (&o_reg_addr) state <= DUMP_MEM;
                    end
                end

                DUMP_MEM: begin
                    if (sending) begin
                        o_dmem_addr <= o_dmem_addr + 1'b1;
                        if (&o_dmem_addr) begin
                            lat_idx <= '0;
                            state   <= DUMP_LAT;
                        end
                    end
                end

                DUMP_LAT: begin
                    if (sending) begin
                        if (lat_idx == LAT_LAST) state <= DUMP_SUM;
                        else lat_idx <= lat_idx + 1'b1;
                    end
                end

                DUMP_SUM: if (sending) state <= IDLE;

                REPLY: if (sending) state <= IDLE;

                default: state <= IDLE;
            endcase

            if (sending) begin
                tx_start_q <= 1'b1;
                tx_data_q  <= send_word;
            end
            if (sending && dump_data) checksum <= checksum ^ send_word;

            if (enter_dump) begin
                o_reg_addr   <= '0;
                o_dmem_addr  <= '0;
                lat_idx      <= '0;
                checksum     <= '0;
                snap_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_debug_controller.sv
// Scoreboard bench for uart_debug_controller: random program loads, run/abort,
// single step and full dumps checked against a behavioural model of the command rules.
module tb_uart_debug_controller;
    localparam int WW   = 32;
    localparam int RB   = 5;
    localparam int DB   = 8;
    localparam int IB   = 2;
    localparam int NL   = 4;
    localparam int LW   = 5;
    localparam int NREG = 1 << RB;
    localparam int NMEM = 1 << DB;
    localparam int NLAT = NL * LW;
    localparam int IMEM_DEPTH = 1 << IB;
    localparam int DUMP_WORDS = NREG + NMEM + NLAT + 1;

    localparam logic [31:0] CMD_RINS = "rins";
    localparam logic [31:0] CMD_IEOF = "ieof";
    localparam logic [31:0] CMD_CONT = "cont";
    localparam logic [31:0] CMD_STEP = "step";
    localparam logic [31:0] CMD_DUMP = "dump";
    localparam logic [31:0] CMD_HALT = "halt";
    localparam logic [31:0] CMD_ABCD = "abcd";

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_debug_controller_if #(.WORD_WIDTH(WW)) u_if ();

    logic                 imem_we;
    logic [IB-1:0]        imem_addr;
    logic [WW-1:0]        imem_data;
    logic                 cpu_reset;
    logic                 run;
    logic                 step;
    logic                 halted;
    logic [RB-1:0]        reg_addr;
    logic [WW-1:0]        reg_data;
    logic [DB-1:0]        dmem_addr;
    logic [WW-1:0]        dmem_data;
    logic [NLAT*WW-1:0]   latches;
    logic [NLAT*WW-1:0]   lat_base;
    logic [WW-1:0]        regs [NREG];
    logic [WW-1:0]        dmem [NMEM];
    logic [WW-1:0]        cpu_cycles;

    uart_debug_controller #(
        .WORD_WIDTH(WW), .REG_ADDR_BITS(RB), .DMEM_ADDR_BITS(DB),
        .IMEM_ADDR_BITS(IB), .N_LATCHES(NL), .LATCH_WORDS(LW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .uart(u_if),
        .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
        .o_cpu_reset(cpu_reset), .o_run(run), .o_step(step), .i_halted(halted),
        .o_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_dmem_addr(dmem_addr), .i_dmem_data(dmem_data),
        .i_latches(latches)
    );

    // Toy CPU: every enabled cycle bumps a counter that shows up in register 1
    // and in the low word of latch 0, so a dump reveals whether the step landed.
    always @(posedge clk) begin
        if (rst) cpu_cycles <= '0;
        else if (run || step) cpu_cycles <= cpu_cycles + 1'b1;
    end
    assign reg_data  = regs[reg_addr] + ((reg_addr == RB'(1)) ? cpu_cycles : '0);
    assign dmem_data = dmem[dmem_addr];
    assign latches   = lat_base ^ {{(NLAT*WW-WW){1'b0}}, cpu_cycles};

    logic [WW-1:0]    exp_tx [$];
    logic [IB+WW-1:0] exp_wr [$];
    int checks = 0;
    int failures = 0;
    int tx_seen = 0;
    int run_cycles = 0;
    int step_pulses = 0;
    int tx_busy = 0;
    logic prev_start = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every DUT transmission and imem write,
    // and plays the UART transmitter (ready drops the cycle after a start).
    always @(negedge clk) begin
        if (run) run_cycles++;
        if (step) step_pulses++;
        if (u_if.o_tx_start) begin
            tx_seen++;
            check("tx_start_spacing", 64'(prev_start), 64'd0);
            if (exp_tx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got %h, required no word", u_if.o_tx_data);
            end else begin
                check("tx_word", 64'(u_if.o_tx_data), 64'(exp_tx.pop_front()));
            end
        end
        if (imem_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL imem_unexpected: got addr %h data %h, required no write", imem_addr, imem_data);
            end else begin
                check("imem_write", 64'({imem_addr, imem_data}), 64'(exp_wr.pop_front()));
            end
        end
        if (rst) begin
            u_if.i_tx_ready = 1'b1;
            tx_busy = 0;
        end else if (prev_start) begin
            u_if.i_tx_ready = 1'b0;
            tx_busy = int'($urandom_range(0, 3));
        end else if (tx_busy > 0) begin
            tx_busy--;
        end else if (!u_if.i_tx_ready) begin
            u_if.i_tx_ready = ($urandom_range(0, 2) != 0);
        end
        prev_start = u_if.o_tx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_word(input logic [WW-1:0] w);
        u_if.i_rx_valid = 1'b1;
        u_if.i_rx_data  = w;
        tick();
        u_if.i_rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 20000) begin
            tick();
            n++;
        end
        check("drain_owed_items", 64'(exp_tx.size() + exp_wr.size()), 64'd0);
        exp_tx.delete();
        exp_wr.delete();
        tick();
        tick();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, 64'({u_if.o_tx_start, imem_we, cpu_reset, run, step}), 64'd0);
        check({name, "_data"}, 64'(u_if.o_tx_data | imem_data), 64'd0);
        check({name, "_addr"}, 64'({imem_addr, reg_addr, dmem_addr}), 64'd0);
    endtask

    task automatic randomize_state();
        for (int a = 0; a < NREG; a++) regs[a] = $urandom;
        for (int a = 0; a < NMEM; a++) dmem[a] = $urandom;
        for (int i = 0; i < NLAT; i++) lat_base[i*WW +: WW] = $urandom;
    endtask

    // Expected dump: every register, every memory word, every latch word, then the XOR of all.
    task automatic push_dump(input logic [WW-1:0] cyc);
        logic [WW-1:0] w;
        logic [WW-1:0] sum;
        sum = '0;
        for (int a = 0; a < NREG; a++) begin
            w = regs[a] + ((a == 1) ? cyc : '0);
            exp_tx.push_back(w);
            sum ^= w;
        end
        for (int a = 0; a < NMEM; a++) begin
            exp_tx.push_back(dmem[a]);
            sum ^= dmem[a];
        end
        for (int k = 0; k < NL; k++) begin
            for (int wd = 0; wd < LW; wd++) begin
                w = lat_base[(k*LW + wd)*WW +: WW];
                if (k == 0 && wd == 0) w ^= cyc;
                exp_tx.push_back(w);
                sum ^= w;
            end
        end
        exp_tx.push_back(sum);
    endtask

    task automatic do_load(input int n);
        logic [WW-1:0] w;
        rx_word(CMD_RINS);
        tick();
        check("cpu_reset_in_load", 64'(cpu_reset), 64'd1);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == CMD_IEOF) w = w ^ 32'h1;
            if (i < IMEM_DEPTH) exp_wr.push_back({IB'(i), w});
            rx_word(w);
        end
        check("cpu_reset_held", 64'(cpu_reset), 64'd1);
        exp_tx.push_back((n > IMEM_DEPTH) ? 32'hEEEE_0001 : WW'(n));
        rx_word(CMD_IEOF);
        drain();
        check("cpu_reset_after_ieof", 64'(cpu_reset), 64'd0);
    endtask

    task automatic do_dump(input logic is_step);
        int t0;
        int s0;
        t0 = tx_seen;
        s0 = step_pulses;
        push_dump(is_step ? cpu_cycles + 1'b1 : cpu_cycles);
        rx_word(is_step ? CMD_STEP : CMD_DUMP);
        tick();
        check("step_at_t2", 64'(step), 64'(is_step));
        drain();
        check("step_pulse_count", 64'(step_pulses - s0), 64'(is_step));
        check("dump_word_count", 64'(tx_seen - t0), 64'(DUMP_WORDS));
    endtask

    initial begin
        int r0;
        int s0;
        int t0;
        int n;
        u_if.i_rx_valid = 1'b0;
        u_if.i_rx_data  = '0;
        halted = 1'b0;
        randomize_state();
        rst = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        do_load(3);
        do_load(6);
        for (int i = 0; i < 3; i++) do_load(int'($urandom_range(0, 7)));

        // Run until the CPU retires HALT after 20 enabled cycles; a stray word is ignored.
        r0 = run_cycles;
        exp_tx.push_back(32'hFFFF_FFFF);
        rx_word(CMD_CONT);
        tick();
        check("run_first_effect", 64'(run), 64'd1);
        repeat (3) tick();
        rx_word(CMD_DUMP);
        repeat (16) tick();
        halted = 1'b1;
        @(negedge clk);
        #1;
        check("run_drops_with_halted", 64'(run), 64'd0);
        check("run_cycle_count", 64'(run_cycles - r0), 64'd20);
        drain();
        halted = 1'b0;

        // Host abort, then abort and HALT together.
        for (int both = 0; both < 2; both++) begin
            exp_tx.push_back(both != 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
            rx_word(CMD_CONT);
            tick();
            repeat ($urandom_range(1, 10)) tick();
            check("run_before_abort", 64'(run), 64'd1);
            u_if.i_rx_valid = 1'b1;
            u_if.i_rx_data  = CMD_HALT;
            halted = (both != 0);
            @(negedge clk);
            #1;
            check("run_drops_with_abort", 64'(run), 64'd0);
            @(posedge clk);
            #1;
            u_if.i_rx_valid = 1'b0;
            drain();
            halted = 1'b0;
        end

        randomize_state();
        do_dump(1'b1);
        randomize_state();
        do_dump(1'b0);

        exp_tx.push_back(32'hEEEE_0000);
        rx_word(CMD_ABCD);
        drain();
        exp_tx.push_back(32'hEEEE_0000);
        rx_word(CMD_HALT);
        drain();
        exp_tx.push_back(32'hEEEE_0000);
        rx_word(CMD_IEOF);
        drain();

        halted = 1'b1;
        s0 = step_pulses;
        exp_tx.push_back(32'hFFFF_FFFF);
        rx_word(CMD_STEP);
        drain();
        check("no_step_when_halted", 64'(step_pulses - s0), 64'd0);
        halted = 1'b0;

        // Reset in the middle of a dump, then a fresh dump from register 0.
        randomize_state();
        push_dump(cpu_cycles);
        t0 = tx_seen;
        rx_word(CMD_DUMP);
        n = 0;
        while ((tx_seen - t0) < 10 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_word_10", 64'(tx_seen - t0), 64'd10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_tx.delete();
        tick();
        check_outputs_zero("mid_dump_reset");
        tick();
        rst = 1'b0;
        tick();
        do_dump(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule

// File: doc/uart_debug_controller.md
# uart_debug_controller

Word-level debug and program-load controller between the UART word buffers and the pipelined CPU. It decodes 32-bit ASCII commands and streams received instructions straight into instruction memory. It runs the CPU continuously or one cycle per command, and dumps registers, data memory and N parametrised pipeline latches back over UART, closing each dump with a checksum word. It generalises the previous UART/pipeline interface with configurable latch count and depth, a true single-step, a host abort, overflow and unknown-command error replies, and direct instruction memory writes with no internal buffer.

## Interface
- WORD_WIDTH, 32, UART word / instruction / data width (at least 32; commands occupy the low 32 bits)
- REG_ADDR_BITS, 5, register bank depth 2^REG_ADDR_BITS
- DMEM_ADDR_BITS, 8, data memory depth 2^DMEM_ADDR_BITS
- IMEM_ADDR_BITS, 6, instruction memory depth 2^IMEM_ADDR_BITS
- N_LATCHES, 4, number of pipeline latches dumped
- LATCH_WORDS, 5, words per latch; each latch is zero-padded to LATCH_WORDS*WORD_WIDTH bits
---
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_valid  in  1  one-cycle pulse: i_rx_data holds a complete received word
- i_rx_data  in  WORD_WIDTH  received word
- i_tx_ready  in  1  transmitter idle; drops the cycle after o_tx_start
- o_tx_start  out  1  one-cycle pulse: send o_tx_data
- o_tx_data  out  WORD_WIDTH  word to transmit; held until next o_tx_start
- o_imem_we  out  1  instruction memory write strobe (one cycle per word)
- o_imem_addr  out  IMEM_ADDR_BITS  write address
- o_imem_data  out  WORD_WIDTH  write data
- o_cpu_reset  out  1  CPU held in reset while loading
- o_run  out  1  CPU clock enable, continuous
- o_step  out  1  CPU clock enable, one-cycle pulse
- i_halted  in  1  program finished (HALT retired)
- o_reg_addr  out  REG_ADDR_BITS  register bank read address; async read, data valid same cycle
- i_reg_data  in  WORD_WIDTH  register value
- o_dmem_addr  out  DMEM_ADDR_BITS  data memory read address; async read
- i_dmem_data  in  WORD_WIDTH  data memory value
- i_latches  in  N_LATCHES*LATCH_WORDS*WORD_WIDTH  latch contents; latch k word w at bits [(k*LATCH_WORDS+w)*WORD_WIDTH +: WORD_WIDTH]

## Operation
- Commands: "rins" load, "ieof" end load, "cont" run, "step" single step, "dump" dump, "halt" abort run.
- States: IDLE, DECODE, LOAD, RUN, STEP, DUMP_REG, DUMP_MEM, DUMP_LAT, DUMP_SUM, REPLY.
- IDLE: on i_rx_valid latch word, go to DECODE. Any other input is ignored.
- DECODE (1 cycle) transitions:
  - "rins" -> LOAD; clear address counter; o_cpu_reset=1.
  - "cont" -> RUN.
  - "step" -> STEP.
  - "dump" -> DUMP_REG.
  - anything else, including stray "halt"/"ieof" -> REPLY with 0xEEEE0000.
- LOAD: each i_rx_valid word other than "ieof" drives o_imem_we=1 next cycle, with o_imem_addr=counter and o_imem_data=word; counter increments.
  - Counter is IMEM_ADDR_BITS+1 wide. Once it reaches 2^IMEM_ADDR_BITS, further words are dropped and an overflow flag is set.
  - "ieof": o_cpu_reset=0; REPLY with the word count zero-extended, or 0xEEEE0001 if overflow.
- RUN: o_run=1 until i_halted or a received "halt". Both drop o_run in the same cycle they are seen and go to REPLY: 0xFFFFFFFF on halt, 0xFFFFFFFE on host abort. i_halted wins if both arrive together. Other words received in RUN are ignored.
- STEP: if i_halted, REPLY 0xFFFFFFFF with no pulse. Otherwise o_step=1 for exactly one cycle, then DUMP_REG.
- Dump order:
  - all registers (addr 0 upward);
  - all data memory words;
  - latch 0 word 0 … latch N_LATCHES-1 word LATCH_WORDS-1;
  - checksum = XOR of every dumped word, sent in DUMP_SUM, then IDLE.
  - Total words = 2^REG_ADDR_BITS + 2^DMEM_ADDR_BITS + N_LATCHES*LATCH_WORDS + 1.
- i_latches is sampled once, on DUMP_REG entry, into a snapshot register.
- REPLY: send one word, then IDLE.
- Reset values: all outputs 0, state IDLE, counters and checksum 0, overflow flag clear. Reset mid-operation aborts immediately; no further o_imem_we or o_tx_start.

## Timing
- Send rule: o_tx_start may pulse only when i_tx_ready=1 and o_tx_start was 0 in the previous cycle. o_tx_data changes only in the pulse cycle.
- In dump states, o_reg_addr/o_dmem_addr equal the index of the word about to be sent. i_*_data is sampled in the o_tx_start cycle, and the index advances the same cycle.
- Command to first effect: i_rx_valid at cycle t; DECODE at t+1; o_run/o_cpu_reset/first o_step asserted from t+2.
- LOAD write latency: 1 cycle after i_rx_valid. Back-to-back i_rx_valid every cycle must be sustained.
- Step: o_step at t+2; DUMP_REG entered at t+3, so the dump reflects the post-step state.

## Test plan
- Reset then "rins", 3 words, "ieof" -> writes to addrs 0,1,2 with the given data, o_cpu_reset high between commands, reply 0x00000003.
- IMEM_ADDR_BITS=2: "rins", 6 words, "ieof" -> exactly 4 writes (addrs 0..3), reply 0xEEEE0001.
- "cont", i_halted after 20 cycles -> o_run high 20 cycles, drops same cycle as i_halted, tx 0xFFFFFFFF; repeat with "halt" word -> tx 0xFFFFFFFE.
- "step" with known regs/mem/latches and i_tx_ready toggling randomly -> exactly one o_step pulse, then words in specified order, total count correct, last word = XOR of all previous, no double o_tx_start.
- Unknown word "abcd" -> tx 0xEEEE0000, return to IDLE; "step" while i_halted=1 -> no o_step, tx 0xFFFFFFFF.
- i_reset asserted mid-dump at word 10 -> next cycle all outputs 0; a fresh "dump" restarts from register 0.
